// File: rtl/feature_pkg.sv
// Shared types and helpers for the feature frame packer.
// Segment length extraction and lane width extension.
package feature_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int MAX_CH    = 8;
    localparam int MAX_LEN_W = 32;
    localparam int MAX_W     = 64;
    localparam int LENS_W    = MAX_CH * MAX_LEN_W;

    // Length of segment i from a packed vector of len_w-bit fields.
    function automatic logic [MAX_LEN_W-1:0] seg_len(
        input logic [LENS_W-1:0] lens,
        input int                len_w,
        input int                i
    );
        logic [MAX_LEN_W-1:0] raw;
        logic [MAX_LEN_W-1:0] mask;
        raw = MAX_LEN_W'(lens >> (i * len_w));
        if (len_w >= MAX_LEN_W) begin
            mask = '1;
        end else begin
            mask = (MAX_LEN_W'(1) << len_w) - MAX_LEN_W'(1);
        end
        return raw & mask;
    endfunction

    // Widen an in_w-bit value, replicating its top bit when sgn is set.
    function automatic logic [MAX_W-1:0] extend(
        input logic [MAX_W-1:0] data,
        input int               in_w,
        input logic             sgn
    );
        logic [MAX_W-1:0] mask;
        logic             msb;
        if (in_w >= MAX_W) begin
            mask = '1;
        end else begin
            mask = (MAX_W'(1) << in_w) - MAX_W'(1);
        end
        msb = |(data & (MAX_W'(1) << (in_w - 1)));
        if (sgn && msb) begin
            return data | ~mask;
        end
        return data & mask;
    endfunction

endpackage

// File: rtl/feature_ch_mux.sv
// Selects the lane of the current channel and widens it to OUT_W.
module feature_ch_mux
    import feature_pkg::*;
#(
    parameter int                NUM_CH      = 2,
    parameter int                IN_W        = 16,
    parameter int                OUT_W       = 16,
    parameter int                SEL_W       = 1,
    parameter logic [NUM_CH-1:0] SIGNED_MASK = '0
) (
    input  logic [NUM_CH*IN_W-1:0] in_data,
    input  logic [SEL_W-1:0]       sel,
    output logic [OUT_W-1:0]       lane
);

    always_comb begin
        lane = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                lane = OUT_W'(extend(MAX_W'(in_data[i*IN_W +: IN_W]),
                                     IN_W, SIGNED_MASK[i]));
            end
        end
    end

endmodule

// File: rtl/feature_frame_packer.sv
// Drains NUM_CH feature streams in channel order into one serial frame
// with first/last markers and a completed-frame counter.
module feature_frame_packer
    import feature_pkg::*;
#(
    parameter int                      NUM_CH      = 2,
    parameter int                      IN_W        = 16,
    parameter int                      OUT_W       = 16,
    parameter int                      LEN_W       = 10,
    parameter logic [NUM_CH*LEN_W-1:0] SEG_LEN     = {10'd64, 10'd256},
    parameter logic [NUM_CH-1:0]       SIGNED_MASK = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init,
    input  logic [NUM_CH*IN_W-1:0] in_data,
    input  logic [NUM_CH-1:0]      in_valid,
    output logic [NUM_CH-1:0]      in_rdy,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_rdy,
    output logic                   out_first,
    output logic                   out_last,
    output logic [15:0]            frame_cnt,
    output logic                   busy
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [LENS_W-1:0] LENS = LENS_W'(SEG_LEN);

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_ch_err
        $error("NUM_CH must be in 1..8");
    end
    if (OUT_W < IN_W) begin : g_w_err
        $error("OUT_W must be at least IN_W");
    end
    if (OUT_W > MAX_W || LEN_W > MAX_LEN_W) begin : g_max_err
        $error("OUT_W or LEN_W exceeds supported width");
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_len_chk
        if (SEG_LEN[g*LEN_W +: LEN_W] == '0) begin : g_len_err
            $error("segment length must be at least 1");
        end
    end

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] cur_len;
    logic [OUT_W-1:0] lane;
    logic             armed;
    logic             can_take;
    logic             fetch;
    logic             seg_end;
    logic             last_ch;

    feature_ch_mux #(
        .NUM_CH      (NUM_CH),
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .SEL_W       (SEL_W),
        .SIGNED_MASK (SIGNED_MASK)
    ) u_mux (
        .in_data (in_data),
        .sel     (sel),
        .lane    (lane)
    );

    always_comb begin
        cur_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                cur_len = LEN_W'(seg_len(LENS, LEN_W, i));
            end
        end
    end

    assign seg_end = (idx == cur_len - LEN_W'(1));
    assign last_ch = (sel == SEL_W'(NUM_CH - 1));

    // armed keeps every ready low until the first clock after reset release.
    assign can_take = armed && !init && (state == RUN)
                   && (!out_valid || out_rdy);
    assign in_rdy   = can_take ? (NUM_CH'(1) << sel) : '0;
    assign fetch    = |(in_rdy & in_valid);
    assign busy     = (sel != '0) || (idx != '0) || (state == FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            sel       <= '0;
            idx       <= '0;
            armed     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            armed <= 1'b1;
            if (init) begin
                state     <= RUN;
                sel       <= '0;
                idx       <= '0;
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                if (fetch) begin
                    out_data  <= lane;
                    out_valid <= 1'b1;
                    out_first <= (sel == '0) && (idx == '0);
                    out_last  <= last_ch && seg_end;
                    if (seg_end) begin
                        idx <= '0;
                        if (last_ch) begin
                            sel   <= '0;
                            state <= FLUSH;
                        end else begin
                            sel <= sel + SEL_W'(1);
                        end
                    end else begin
                        idx <= idx + LEN_W'(1);
                    end
                end else if (out_rdy) begin
                    out_valid <= 1'b0;
                end
                // The frame only counts once its final element has left.
                if (state == FLUSH && (!out_valid || out_rdy)) begin
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_feature_frame_packer.sv
// Scoreboard bench for feature_frame_packer (IN_W=8, ch1 signed).
module tb_feature_frame_packer;

    logic        clk;
    logic        rst_n;
    logic        init;
    logic [15:0] in_data;
    logic [1:0]  in_valid;
    logic [1:0]  in_rdy;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_rdy;
    logic        out_first;
    logic        out_last;
    logic [15:0] frame_cnt;
    logic        busy;

    feature_frame_packer #(
        .NUM_CH      (2),
        .IN_W        (8),
        .OUT_W       (16),
        .LEN_W       (10),
        .SEG_LEN     ({10'd64, 10'd256}),
        .SIGNED_MASK (2'b10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_rdy   (out_rdy),
        .out_first (out_first),
        .out_last  (out_last),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [17:0] expq[$];
    logic        en0 = 1'b1;
    logic        en1 = 1'b1;
    logic        rmode = 1'b0;
    int          acc_cnt = 0;
    logic        gap_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic drive();
        in_valid = '0;
        in_data  = '0;
        if (en0 && q0.size() > 0) begin
            in_valid[0]  = 1'b1;
            in_data[7:0] = q0[0];
        end
        if (en1 && q1.size() > 0) begin
            in_valid[1]   = 1'b1;
            in_data[15:8] = q1[0];
        end
        out_rdy = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // mode 0: ramps; mode 1: every element 8'hF0 on both channels
    task automatic push_frame(input int mode);
        logic [7:0] d;
        for (int i = 0; i < 256; i++) begin
            d = (mode == 1) ? 8'hF0 : 8'(i);
            q0.push_back(d);
            expq.push_back({(i == 0), 1'b0,
                            (mode == 1) ? 16'h00F0 : {8'h00, d}});
        end
        for (int i = 0; i < 64; i++) begin
            d = (mode == 1) ? 8'hF0 : 8'(i);
            q1.push_back(d);
            expq.push_back({1'b0, (i == 63),
                            (mode == 1) ? 16'hFFF0 : {8'h00, d}});
        end
    endtask

    // Source side: sample handshake away from the edge, advance after it.
    logic t0;
    logic t1;
    always begin
        @(negedge clk);
        t0 = in_valid[0] & in_rdy[0];
        t1 = in_valid[1] & in_rdy[1];
        @(posedge clk);
        #1;
        if (t0 && q0.size() > 0) void'(q0.pop_front());
        if (t1 && q1.size() > 0) void'(q1.pop_front());
        acc_cnt += int'(t0) + int'(t1);
        drive();
    end

    // Monitor: compare every accepted output against the scoreboard.
    int          cyc = 0;
    int          last_cyc = -1;
    logic        hold = 1'b0;
    logic [15:0] held = '0;
    logic [17:0] e;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n || init) begin
            hold = 1'b0;
        end else begin
            if (hold && out_valid) chk("stall_stable", out_data, held);
            if (out_valid && !out_rdy) chk("stall_in_rdy", in_rdy, 2'b00);
            hold = out_valid && !out_rdy;
            held = out_data;
            if (out_valid && out_rdy) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out", out_data, 16'hxxxx);
                end else begin
                    e = expq.pop_front();
                    chk("elem", {out_first, out_last, out_data}, e);
                    if (out_first && gap_chk && last_cyc >= 0)
                        chk("frame_gap", cyc - last_cyc, 2);
                    if (out_last) last_cyc = cyc;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int n, input string name);
        int k;
        k = 0;
        while (acc_cnt < n && k < 2000) begin
            step();
            k++;
        end
        if (acc_cnt != n) chk(name, acc_cnt, n);
    endtask

    task automatic drain(input int budget, input logic [15:0] fc,
                         input string name);
        int k;
        k = 0;
        while (expq.size() != 0 && k < budget) begin
            step();
            k++;
        end
        if (expq.size() != 0) chk({name, "_timeout"}, expq.size(), 0);
        repeat (3) step();
        chk({name, "_frame_cnt"}, frame_cnt, fc);
        chk({name, "_busy"}, busy, 1'b0);
    endtask

    logic [15:0] saved_fc;
    logic        bad;

    initial begin
        rst_n    = 1'b0;
        init     = 1'b0;
        in_valid = '0;
        in_data  = '0;
        out_rdy  = 1'b0;
        #3;
        chk("rst_in_rdy", in_rdy, 2'b00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_first_last", {out_first, out_last}, 2'b00);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_busy", busy, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // two back-to-back ramp frames, steady flow
        gap_chk = 1'b1;
        acc_cnt = 0;
        push_frame(0);
        push_frame(0);
        drive();
        drain(2000, 16'd2, "steady");
        gap_chk = 1'b0;

        // extension: ch0 zero-extended, ch1 sign-extended
        push_frame(1);
        drive();
        drain(1000, 16'd3, "extend");

        // random back-pressure
        rmode = 1'b1;
        push_frame(0);
        drive();
        drain(3000, 16'd4, "backpressure");
        rmode = 1'b0;

        // ch1 starved at idx 10
        acc_cnt = 0;
        push_frame(0);
        drive();
        wait_acc(266, "starve_reach");
        en1 = 1'b0;
        drive();
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (in_rdy[0]) bad = 1'b1;
            if (i == 3) chk("starve_out_valid", out_valid, 1'b0);
        end
        chk("starve_in_rdy0", bad, 1'b0);
        chk("starve_acc", acc_cnt, 266);
        en1 = 1'b1;
        drive();
        drain(1000, 16'd5, "starve");

        // init at ch0 idx 100 with an element held
        acc_cnt = 0;
        push_frame(0);
        drive();
        wait_acc(100, "init_reach");
        chk("init_pre_valid", out_valid, 1'b1);
        saved_fc = frame_cnt;
        init = 1'b1;
        q0.delete();
        q1.delete();
        expq.delete();
        drive();
        step();
        init = 1'b0;
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_busy", busy, 1'b0);
        chk("init_frame_cnt", frame_cnt, saved_fc);
        push_frame(0);
        drive();
        drain(1000, 16'd6, "after_init");

        // asynchronous reset at ch1 idx 5
        acc_cnt = 0;
        push_frame(0);
        drive();
        wait_acc(261, "reset_reach");
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_in_rdy", in_rdy, 2'b00);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_data", out_data, 16'h0000);
        chk("arst_first_last", {out_first, out_last}, 2'b00);
        chk("arst_frame_cnt", frame_cnt, 16'd0);
        chk("arst_busy", busy, 1'b0);
        q0.delete();
        q1.delete();
        expq.delete();
        drive();
        repeat (2) step();
        rst_n = 1'b1;
        push_frame(0);
        drive();
        drain(1000, 16'd1, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
